// File: rtl/data_register_pkg.sv
// Shared definitions for data_register: default width, next-state priority
// encoding and the parity helper used when DATA_REGISTER_PARITY_EN is defined.
package data_register_pkg;

  localparam int unsigned DATA_REGISTER_DEFAULT_WIDTH = 8;
  localparam int unsigned DATA_REGISTER_MAX_WIDTH     = 64;

  typedef enum logic [1:0] {
    PRIO_RESET,
    PRIO_CLEAR,
    PRIO_LOAD,
    PRIO_HOLD
  } data_register_prio_e;

  // Callers zero-extend narrower words; extra zeros leave the XOR unchanged.
  function automatic logic even_parity(input logic [DATA_REGISTER_MAX_WIDTH-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/data_register_next.sv
// Combinational next-state selection for data_register (reset > clr > en > hold).
// Next-parity logic exists only when DATA_REGISTER_PARITY_EN is defined.
module data_register_next
  import data_register_pkg::*;
#(
  parameter int unsigned    N           = DATA_REGISTER_DEFAULT_WIDTH,
  parameter logic [N-1:0]   RESET_VALUE = '0,
  parameter logic [N-1:0]   CLEAR_VALUE = '0
) (
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  input  logic [N-1:0] q_i,
`ifdef DATA_REGISTER_PARITY_EN
  input  logic         par_i,
  output logic         par_d_o,
`endif
  output logic [N-1:0] q_d_o
);

  data_register_prio_e prio;

  always_comb begin
    prio = PRIO_HOLD;
    if (reset_i)    prio = PRIO_RESET;
    else if (clr_i) prio = PRIO_CLEAR;
    else if (en_i)  prio = PRIO_LOAD;
  end

  always_comb begin
    q_d_o = q_i;
    case (prio)
      PRIO_RESET: q_d_o = RESET_VALUE;
      PRIO_CLEAR: q_d_o = CLEAR_VALUE;
      PRIO_LOAD:  q_d_o = d_i;
      default:    q_d_o = q_i;
    endcase
  end

`ifdef DATA_REGISTER_PARITY_EN
  function automatic logic [DATA_REGISTER_MAX_WIDTH-1:0] widen(input logic [N-1:0] x);
    logic [DATA_REGISTER_MAX_WIDTH-1:0] w;
    w = '0;
    w[N-1:0] = x;
    return w;
  endfunction

  always_comb begin
    par_d_o = par_i;
    case (prio)
      PRIO_RESET: par_d_o = even_parity(widen(RESET_VALUE));
      PRIO_CLEAR: par_d_o = even_parity(widen(CLEAR_VALUE));
      PRIO_LOAD:  par_d_o = even_parity(widen(d_i));
      default:    par_d_o = par_i;
    endcase
  end
`endif

endmodule

// File: rtl/data_register.sv
// N-bit edge-triggered register with synchronous reset/clear and load enable.
// Optional registered even-parity output q_par via DATA_REGISTER_PARITY_EN.
module data_register
  import data_register_pkg::*;
#(
  parameter int unsigned  N           = DATA_REGISTER_DEFAULT_WIDTH,
  parameter logic [N-1:0] RESET_VALUE = '0,
  parameter logic [N-1:0] CLEAR_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q
`ifdef DATA_REGISTER_PARITY_EN
  ,
  output logic         q_par
`endif
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

`ifdef DATA_REGISTER_PARITY_EN
  logic par_q;
  logic par_d;
`endif

  data_register_next #(
    .N           (N),
    .RESET_VALUE (RESET_VALUE),
    .CLEAR_VALUE (CLEAR_VALUE)
  ) u_next (
    .reset_i (reset),
    .clr_i   (clr),
    .en_i    (en),
    .d_i     (D),
    .q_i     (q_q),
`ifdef DATA_REGISTER_PARITY_EN
    .par_i   (par_q),
    .par_d_o (par_d),
`endif
    .q_d_o   (q_d)
  );

  // Reset priority lives in data_register_next, so the flops load unconditionally.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign Q = q_q;

`ifdef DATA_REGISTER_PARITY_EN
  always_ff @(posedge clk) begin
    par_q <= par_d;
  end

  assign q_par = par_q;
`endif

endmodule

// File: tb/tb_data_register.sv
// Directed self-checking bench for data_register at N=8 (two value sets), N=1 and N=32.
module tb_data_register;

  logic        clk;
  logic        reset;
  logic        en;
  logic        clr;
  logic [7:0]  d8;
  logic [0:0]  d1;
  logic [31:0] d32;
  logic [7:0]  q0;
  logic [7:0]  q1;
  logic [0:0]  q2;
  logic [31:0] q3;
  int          checks;
  int          errors;
  bit          seen_reset;

`ifdef DATA_REGISTER_PARITY_EN
  logic p0, p1, p2, p3;
`endif

  data_register #(.N(8)) dut0 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .D(d8), .Q(q0)
`ifdef DATA_REGISTER_PARITY_EN
    , .q_par(p0)
`endif
  );

  data_register #(.N(8), .RESET_VALUE(8'hA5), .CLEAR_VALUE(8'h3D)) dut1 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .D(d8), .Q(q1)
`ifdef DATA_REGISTER_PARITY_EN
    , .q_par(p1)
`endif
  );

  data_register #(.N(1)) dut2 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .D(d1), .Q(q2)
`ifdef DATA_REGISTER_PARITY_EN
    , .q_par(p2)
`endif
  );

  data_register #(.N(32)) dut3 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .D(d32), .Q(q3)
`ifdef DATA_REGISTER_PARITY_EN
    , .q_par(p3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; clr = 1'b0;
    d8 = 8'd133; d1 = 1'b1; d32 = 32'hFFFF_FFFF;
    tick();
    seen_reset = 1'b1;
    checks++; if (q0 !== 8'd0)  begin errors++; $display("FAIL reset_q0: got %h want %h", q0, 8'd0); end
    checks++; if (q1 !== 8'hA5) begin errors++; $display("FAIL reset_q1: got %h want %h", q1, 8'hA5); end
    checks++; if (q2 !== 1'b0)  begin errors++; $display("FAIL reset_q2: got %h want %h", q2, 1'b0); end
    checks++; if (q3 !== 32'd0) begin errors++; $display("FAIL reset_q3: got %h want %h", q3, 32'd0); end
    tick();
    checks++; if (q1 !== 8'hA5) begin errors++; $display("FAIL reset_held_q1: got %h want %h", q1, 8'hA5); end
    reset = 1'b0;
    tick();
    checks++; if (q0 !== 8'd133) begin errors++; $display("FAIL first_load_q0: got %h want %h", q0, 8'd133); end
    checks++; if (q1 !== 8'd133) begin errors++; $display("FAIL first_load_q1: got %h want %h", q1, 8'd133); end
  endtask

  task automatic test_no_transparency();
    @(negedge clk);
    d8 = 8'd222;
    #1;
    checks++; if (q0 !== 8'd133) begin errors++; $display("FAIL transp_222: got %h want %h", q0, 8'd133); end
    #1;
    d8 = 8'd54;
    #1;
    checks++; if (q0 !== 8'd133) begin errors++; $display("FAIL transp_54: got %h want %h", q0, 8'd133); end
    tick();
    checks++; if (q0 !== 8'd54) begin errors++; $display("FAIL transp_load: got %h want %h", q0, 8'd54); end
  endtask

  task automatic test_enable_hold();
    en = 1'b0; d8 = 8'd222;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q0 !== 8'd54) begin errors++; $display("FAIL hold_%0d: got %h want %h", i, q0, 8'd54); end
    end
    en = 1'b1;
    tick();
    checks++; if (q0 !== 8'd222) begin errors++; $display("FAIL hold_release: got %h want %h", q0, 8'd222); end
  endtask

  task automatic test_priority();
    clr = 1'b1; en = 1'b1; d8 = 8'hFF;
    tick();
    checks++; if (q0 !== 8'h00) begin errors++; $display("FAIL clr_over_en_q0: got %h want %h", q0, 8'h00); end
    checks++; if (q1 !== 8'h3D) begin errors++; $display("FAIL clr_over_en_q1: got %h want %h", q1, 8'h3D); end
    reset = 1'b1;
    tick();
    checks++; if (q0 !== 8'h00) begin errors++; $display("FAIL rst_over_clr_q0: got %h want %h", q0, 8'h00); end
    checks++; if (q1 !== 8'hA5) begin errors++; $display("FAIL rst_over_clr_q1: got %h want %h", q1, 8'hA5); end
    reset = 1'b0; clr = 1'b0;
    tick();
    checks++; if (q0 !== 8'hFF) begin errors++; $display("FAIL post_prio_load: got %h want %h", q0, 8'hFF); end
  endtask

  task automatic test_width_sweep();
    en = 1'b1; d1 = 1'b1; d32 = 32'hFFFF_FFFF;
    tick();
    checks++; if (q2 !== 1'b1)         begin errors++; $display("FAIL w1_ones: got %h want %h", q2, 1'b1); end
    checks++; if (q3 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL w32_ones: got %h want %h", q3, 32'hFFFF_FFFF); end
    d1 = 1'b0; d32 = 32'h5555_5555;
    tick();
    checks++; if (q2 !== 1'b0)         begin errors++; $display("FAIL w1_zero: got %h want %h", q2, 1'b0); end
    checks++; if (q3 !== 32'h5555_5555) begin errors++; $display("FAIL w32_55: got %h want %h", q3, 32'h5555_5555); end
    d32 = 32'hAAAA_AAAA; en = 1'b0;
    tick();
    checks++; if (q3 !== 32'h5555_5555) begin errors++; $display("FAIL w32_hold: got %h want %h", q3, 32'h5555_5555); end
    en = 1'b1;
    tick();
    checks++; if (q3 !== 32'hAAAA_AAAA) begin errors++; $display("FAIL w32_aa: got %h want %h", q3, 32'hAAAA_AAAA); end
  endtask

`ifdef DATA_REGISTER_PARITY_EN
  task automatic test_parity();
    en = 1'b1; d8 = 8'h07;
    tick();
    checks++; if (p0 !== 1'b1) begin errors++; $display("FAIL par_07: got %b want %b", p0, 1'b1); end
    d8 = 8'h03;
    tick();
    checks++; if (p0 !== 1'b0) begin errors++; $display("FAIL par_03: got %b want %b", p0, 1'b0); end
    clr = 1'b1;
    tick();
    checks++; if (p1 !== 1'b1) begin errors++; $display("FAIL par_clr_3D: got %b want %b", p1, 1'b1); end
    clr = 1'b0; reset = 1'b1;
    tick();
    checks++; if (p1 !== 1'b0) begin errors++; $display("FAIL par_rst_A5: got %b want %b", p1, 1'b0); end
    reset = 1'b0; en = 1'b0;
    tick();
    checks++; if (p1 !== 1'b0) begin errors++; $display("FAIL par_hold: got %b want %b", p1, 1'b0); end
  endtask

  // Parity must track Q on every cycle once reset has been applied.
  always @(negedge clk) begin
    if (seen_reset) begin
      checks++;
      if (p0 !== ^q0 || p1 !== ^q1 || p2 !== ^q2 || p3 !== ^q3) begin
        errors++;
        $display("FAIL par_invariant: got %b%b%b%b want %b%b%b%b",
                 p0, p1, p2, p3, ^q0, ^q1, ^q2, ^q3);
      end
    end
  end
`endif

  initial begin
    checks = 0; errors = 0; seen_reset = 1'b0;
    reset = 1'b0; en = 1'b0; clr = 1'b0;
    d8 = '0; d1 = '0; d32 = '0;
    test_reset();
    test_no_transparency();
    test_enable_hold();
    test_priority();
    test_width_sweep();
`ifdef DATA_REGISTER_PARITY_EN
    test_parity();
`endif
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
